// File: rtl/multi_sort_pkg.sv
// multi_sort_pkg: shared state encoding, width-free constants and the popcount helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multi_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_e;

  // Widest request mask the popcount helper accepts.
  localparam int MAX_CLIENTS_C = 64;

  function automatic int unsigned popcount(input logic [MAX_CLIENTS_C-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CLIENTS_C; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sort_stage.sv
// sort_stage: one slot of the insertion-sort chain (occ, client, val).
// Latency: slot updates on the edge that ends the insert cycle.
// Backpressure: none; the owning FSM gates en and clr.
// Ports: clk/rst, clr (empty the slot), en + new_client/new_val (entry
// being inserted), prev_ent/prev_win (slot above), ent/win (this slot).
module sort_stage #(
  parameter int CB = 2,
  parameter int VW = 8,
  localparam int EW = 1 + CB + VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CB-1:0] new_client,
  input  logic [VW-1:0] new_val,
  input  logic [EW-1:0] prev_ent,
  input  logic          prev_win,
  output logic [EW-1:0] ent,
  output logic          win
);

  typedef struct packed {
    logic          occ;
    logic [CB-1:0] client;
    logic [VW-1:0] val;
  } entry_t;

  entry_t cur;

  assign ent = cur;

  // Strictly greater: an equal newcomer lands behind the incumbent, which
  // keeps lower-index clients ahead on ties.
  assign win = en & (~cur.occ | (new_val > cur.val));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur <= '0;
    end else if (win) begin
      // Slot above also won: the insertion point is higher, so shift down.
      cur <= prev_win ? entry_t'(prev_ent)
                      : entry_t'{occ: 1'b1, client: new_client, val: new_val};
    end
  end

endmodule

// File: rtl/multi_sort.sv
// multi_sort: snapshots per-client priorities and ranks requesting clients, highest first.
// Latency: CLIENTS_P+1 cycles from accepted start to out_valid, independent of the mask.
// Backpressure: DONE holds the result until out_ready; start is ignored in SORT and in a stalled DONE.
// Ports: clk/rst; start + req_mask/req_vals (snapshot request); busy while
// sorting; out_valid/out_ready handshake; sorted_client/sorted_val/sorted_occ
// per slot (slot 0 highest) and num_valid (occupied slot count).
module multi_sort
  import multi_sort_pkg::*;
#(
  parameter int CLIENTS_P        = 4,
  parameter int CLIENTS_BWIDTH_P = $clog2(CLIENTS_P),
  parameter int VAL_WIDTH_P      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CLIENTS_P-1:0]                  req_mask,
  input  logic [CLIENTS_P*VAL_WIDTH_P-1:0]      req_vals,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CLIENTS_P*CLIENTS_BWIDTH_P-1:0] sorted_client,
  output logic [CLIENTS_P*VAL_WIDTH_P-1:0]      sorted_val,
  output logic [CLIENTS_P-1:0]                  sorted_occ,
  output logic [CLIENTS_BWIDTH_P:0]             num_valid
);

  localparam int CB   = CLIENTS_BWIDTH_P;
  localparam int VW   = VAL_WIDTH_P;
  localparam int NV_W = CLIENTS_BWIDTH_P + 1;

  typedef struct packed {
    logic          occ;
    logic [CB-1:0] client;
    logic [VW-1:0] val;
  } entry_t;

  sort_state_e state, state_nxt;
  logic                    load;
  logic [CB-1:0]           k;
  logic [CLIENTS_P-1:0]    snap_mask;
  logic [CLIENTS_P*VW-1:0] snap_vals;
  logic [VW-1:0]           snap_val [CLIENTS_P];
  logic                    ins_en;
  entry_t                  ent_s [CLIENTS_P];
  logic                    win_s [CLIENTS_P];

  localparam logic [CB-1:0] K_LAST = CB'(CLIENTS_P - 1);

  // Next-state: load marks a snapshot (from IDLE, or back-to-back from DONE).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SORT;
        end
      end
      SORT: begin
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            load      = 1'b1;
            state_nxt = SORT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      snap_mask <= '0;
      snap_vals <= '0;
      num_valid <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        snap_mask <= req_mask;
        snap_vals <= req_vals;
        num_valid <= NV_W'(popcount(MAX_CLIENTS_C'(req_mask)));
        k         <= '0;
      end else if (state == SORT) begin
        // Masked clients still consume their cycle, so latency is fixed.
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end
    end
  end

  assign busy      = (state == SORT);
  assign out_valid = (state == DONE);
  assign ins_en    = (state == SORT) & snap_mask[k];

  for (genvar c = 0; c < CLIENTS_P; c++) begin : g_unpack
    assign snap_val[c] = snap_vals[c*VW +: VW];
  end

  for (genvar s = 0; s < CLIENTS_P; s++) begin : g_stage
    logic [1+CB+VW-1:0] prev_ent;
    logic               prev_win;

    if (s == 0) begin : g_top
      assign prev_ent = '0;
      assign prev_win = 1'b0;
    end else begin : g_chain
      assign prev_ent = ent_s[s-1];
      assign prev_win = win_s[s-1];
    end

    sort_stage #(
      .CB (CB),
      .VW (VW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .clr        (load),
      .en         (ins_en),
      .new_client (k),
      .new_val    (snap_val[k]),
      .prev_ent   (prev_ent),
      .prev_win   (prev_win),
      .ent        (ent_s[s]),
      .win        (win_s[s])
    );

    assign sorted_client[s*CB +: CB] = ent_s[s].client;
    assign sorted_val[s*VW +: VW]    = ent_s[s].val;
    assign sorted_occ[s]             = ent_s[s].occ;
  end

endmodule

// File: tb/tb_multi_sort.sv
// tb_multi_sort: checks a 4x8 and an 8x12 multi_sort against a selection-sort model.
// Latency: every run expects out_valid exactly CLIENTS_P+1 cycles after start.
// Backpressure: exercises DONE stalls, back-to-back restart and mid-sort reset.
module tb_multi_sort;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4 clients, 8-bit values.
  logic        a_start = 0, a_ordy = 0;
  logic [3:0]  a_mask = 0;
  logic [31:0] a_vals = 0;
  logic        a_busy, a_ov;
  logic [7:0]  a_sc;
  logic [31:0] a_sv;
  logic [3:0]  a_occ;
  logic [2:0]  a_nv;

  // Instance B: 8 clients, 12-bit values.
  logic        b_start = 0, b_ordy = 0;
  logic [7:0]  b_mask = 0;
  logic [95:0] b_vals = 0;
  logic        b_busy, b_ov;
  logic [23:0] b_sc;
  logic [95:0] b_sv;
  logic [7:0]  b_occ;
  logic [3:0]  b_nv;

  multi_sort #(.CLIENTS_P(4), .VAL_WIDTH_P(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .req_mask(a_mask), .req_vals(a_vals),
    .busy(a_busy), .out_valid(a_ov), .out_ready(a_ordy),
    .sorted_client(a_sc), .sorted_val(a_sv), .sorted_occ(a_occ), .num_valid(a_nv)
  );

  multi_sort #(.CLIENTS_P(8), .VAL_WIDTH_P(12)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .req_mask(b_mask), .req_vals(b_vals),
    .busy(b_busy), .out_valid(b_ov), .out_ready(b_ordy),
    .sorted_client(b_sc), .sorted_val(b_sv), .sorted_occ(b_occ), .num_valid(b_nv)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected result of the most recent run on each instance.
  logic [127:0] a_ec, a_ev, b_ec, b_ev;
  logic [7:0]   a_eo, b_eo;
  int           a_en, b_en;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: repeatedly pick the largest remaining requesting value,
  // lowest client index winning ties; unused slots stay all-zero.
  task automatic ref_sort(input int n, input int cb, input int vw,
                          input logic [7:0] mask, input logic [95:0] vals,
                          output logic [127:0] ec, output logic [127:0] ev,
                          output logic [7:0] eo, output int nv);
    bit taken [8];
    int v [8];
    ec = '0; ev = '0; eo = '0; nv = 0;
    for (int c = 0; c < 8; c++) begin
      taken[c] = 1'b0;
      v[c] = int'((vals >> (c*vw)) & ((96'd1 << vw) - 96'd1));
    end
    for (int r = 0; r < n; r++) begin
      int best;
      best = -1;
      for (int c = 0; c < n; c++) begin
        if (mask[c] && !taken[c] && (best < 0 || v[c] > v[best])) best = c;
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        ec = ec | (128'(best) << (r*cb));
        ev = ev | (128'(v[best]) << (r*vw));
        eo[r] = 1'b1;
        nv++;
      end
    end
  endtask

  // Starts a sort (from IDLE, or back-to-back from DONE) and checks the
  // full latency profile and the final ranking.
  task automatic run_a(input logic [3:0] m, input logic [31:0] v, input string tag);
    ref_sort(4, 2, 8, {4'b0, m}, {64'b0, v}, a_ec, a_ev, a_eo, a_en);
    @(negedge clk);
    a_start = 1; a_ordy = 1; a_mask = m; a_vals = v;
    @(negedge clk);
    a_start = 0; a_ordy = 0; a_mask = 4'($urandom); a_vals = $urandom;
    chk({tag, ":busy1"}, a_busy, 1'b1);
    chk({tag, ":ov_early"}, a_ov, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk({tag, ":ov_sorting"}, a_ov, 1'b0);
    end
    @(negedge clk);
    chk({tag, ":ov"}, a_ov, 1'b1);
    chk({tag, ":busy_done"}, a_busy, 1'b0);
    chk({tag, ":client"}, a_sc, a_ec);
    chk({tag, ":val"}, a_sv, a_ev);
    chk({tag, ":occ"}, a_occ, a_eo);
    chk({tag, ":nv"}, a_nv, a_en);
  endtask

  task automatic run_b(input logic [7:0] m, input logic [95:0] v, input string tag);
    ref_sort(8, 3, 12, m, v, b_ec, b_ev, b_eo, b_en);
    @(negedge clk);
    b_start = 1; b_ordy = 1; b_mask = m; b_vals = v;
    @(negedge clk);
    b_start = 0; b_ordy = 0; b_mask = 8'($urandom);
    chk({tag, ":busy1"}, b_busy, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk({tag, ":ov_sorting"}, b_ov, 1'b0);
    end
    @(negedge clk);
    chk({tag, ":ov"}, b_ov, 1'b1);
    chk({tag, ":client"}, b_sc, b_ec);
    chk({tag, ":val"}, b_sv, b_ev);
    chk({tag, ":occ"}, b_occ, b_eo);
    chk({tag, ":nv"}, b_nv, b_en);
  endtask

  task automatic consume_a();
    @(negedge clk);
    a_ordy = 1;
    @(negedge clk);
    a_ordy = 0;
    chk("a_consume:ov", a_ov, 1'b0);
    chk("a_consume:busy", a_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] bv;
    logic [7:0]  bm;

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset:busy", a_busy, 1'b0);
    chk("reset:ov", a_ov, 1'b0);
    chk("reset:client", a_sc, 0);
    chk("reset:val", a_sv, 0);
    chk("reset:occ", a_occ, 0);
    chk("reset:nv", a_nv, 0);
    chk("reset_b:ov", b_ov, 1'b0);

    // Basic ranking with hard-coded expectations.
    run_a(4'b1111, 32'h1E_14_28_0A, "t1");
    chk("t1_const:client", a_sc, 8'h2D);
    chk("t1_const:val", a_sv, 32'h0A141E28);
    consume_a();

    // Equal values keep client order.
    run_a(4'b1111, 32'h07070707, "t2_ties");
    chk("t2_const:client", a_sc, 8'hE4);
    consume_a();

    // Zero-valued requester ranks; masked clients excluded.
    run_a(4'b1010, 32'h05_63_00_63, "t3_mask");
    chk("t3_const:client", a_sc, 8'h07);
    chk("t3_const:val", a_sv, 32'h00000005);
    chk("t3_const:occ", a_occ, 4'b0011);
    chk("t3_const:nv", a_nv, 3'd2);

    // Stall in DONE: start ignored, outputs held.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_start = 1; a_ordy = 0; a_mask = 4'b1111; a_vals = $urandom;
      @(negedge clk);
      chk("t4_hold:ov", a_ov, 1'b1);
      chk("t4_hold:busy", a_busy, 1'b0);
      chk("t4_hold:client", a_sc, a_ec);
      chk("t4_hold:val", a_sv, a_ev);
      chk("t4_hold:nv", a_nv, a_en);
    end
    a_start = 0;
    // Back-to-back restart straight from DONE.
    run_a(4'b0111, $urandom, "t4_b2b");
    run_a(4'b1101, $urandom, "t4_b2b2");
    consume_a();

    // Reset during the third SORT cycle.
    @(negedge clk);
    a_start = 1; a_mask = 4'b1111; a_vals = $urandom;
    @(negedge clk);
    a_start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_rst:busy", a_busy, 1'b0);
    chk("t5_rst:ov", a_ov, 1'b0);
    chk("t5_rst:client", a_sc, 0);
    chk("t5_rst:val", a_sv, 0);
    chk("t5_rst:occ", a_occ, 0);
    chk("t5_rst:nv", a_nv, 0);
    run_a(4'b1111, $urandom, "t5_after");
    consume_a();

    // Empty masks on both widths.
    run_a(4'b0000, $urandom, "t6_empty_a");
    chk("t6_empty_a:occ0", a_occ, 4'b0000);
    consume_a();
    run_b(8'h00, {$urandom, $urandom, $urandom}, "t6_empty_b");
    chk("t6_empty_b:occ0", b_occ, 8'h00);

    // Randomised 8x12 runs; alternate wide values and tie-heavy small values.
    for (int it = 0; it < 1000; it++) begin
      bv = '0;
      for (int c = 0; c < 8; c++) begin
        bv[c*12 +: 12] = (it % 2 == 1) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
      end
      bm = (it % 7 == 0) ? 8'hFF : 8'($urandom);
      run_b(bm, bv, "t6_rand");
      if (it % 3 == 0) begin
        @(negedge clk);
        b_ordy = 1;
        @(negedge clk);
        b_ordy = 0;
        chk("t6_consume:ov", b_ov, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
